lcd_bus_receiver: RTL and testbench

LCD_BUS_RECEIVER -- requirements
Module: lcd_bus_receiver

---
 rtl/lcd_bus_receiver_if.sv | 25 ++
 rtl/lcd_bus_receiver.sv | 143 ++++++++++++++
 tb/tb_lcd_bus_receiver.sv | 200 ++++++++++++++++++++
 3 files changed

// File: rtl/lcd_bus_receiver_if.sv
// Bus bundle between an HD44780-style host and the receiver.
// Carries the write strobe lines plus the buffer read port and status.
interface lcd_bus_receiver_if;
   logic       LCD_E;
   logic       LCD_RS;
   logic       LCD_RW;
   logic [7:0] LCD_DATA;
   logic [4:0] RD_ADDR;
   logic [7:0] RD_CHAR;
   logic [6:0] ADDR_CNT;
   logic       DISP_ON;
   logic       BUSY;
   logic       WR_PULSE;
   logic       BUSY_ERR;

   modport master (
      output LCD_E, LCD_RS, LCD_RW, LCD_DATA, RD_ADDR,
      input  RD_CHAR, ADDR_CNT, DISP_ON, BUSY, WR_PULSE, BUSY_ERR
   );

   modport slave (
      input  LCD_E, LCD_RS, LCD_RW, LCD_DATA, RD_ADDR,
      output RD_CHAR, ADDR_CNT, DISP_ON, BUSY, WR_PULSE, BUSY_ERR
   );
endinterface

// File: rtl/lcd_bus_receiver.sv
// Emulates the write side of an HD44780 controller: decodes strobes on the
// falling edge of LCD_E into a 2x16 character buffer plus busy/status flags.
module lcd_bus_receiver #(
   parameter int unsigned CLR_CYCLES = 1640,
   parameter int unsigned CMD_CYCLES = 40
) (
   input  logic CLK_1M,
   input  logic RESET,
   lcd_bus_receiver_if.slave bus
);

   localparam int unsigned MAX_CYC = (CLR_CYCLES > CMD_CYCLES) ? CLR_CYCLES : CMD_CYCLES;
   localparam int unsigned CNT_W   = $clog2(MAX_CYC + 1);
   localparam int unsigned DEPTH   = 32;

   logic             e_s1, e_s2, e_d;
   logic             rs_s1, rs_s2;
   logic             rw_s1, rw_s2;
   logic [7:0]       data_s1, data_s2;

   logic [6:0]       addr, addr_nx;
   logic             id, id_nx;
   logic             disp, disp_nx;
   logic [CNT_W-1:0] cnt, cnt_nx;
   logic             busy, busy_nx;
   logic             wr, wr_nx;
   logic             err, err_nx;
   logic [7:0]       mem [DEPTH];

   logic             fall_c;
   logic             store_c;
   logic [4:0]       store_idx_c;
   logic             clear_c;

   // Two-flop synchronizers for every bus input, plus the edge-detect history flop
   always_ff @(posedge CLK_1M or negedge RESET) begin
      if (!RESET) begin
         e_s1    <= 1'b0;
         e_s2    <= 1'b0;
         e_d     <= 1'b0;
         rs_s1   <= 1'b0;
         rs_s2   <= 1'b0;
         rw_s1   <= 1'b0;
         rw_s2   <= 1'b0;
         data_s1 <= 8'h00;
         data_s2 <= 8'h00;
      end else begin
         e_s1    <= bus.LCD_E;
         e_s2    <= e_s1;
         e_d     <= e_s2;
         rs_s1   <= bus.LCD_RS;
         rs_s2   <= rs_s1;
         rw_s1   <= bus.LCD_RW;
         rw_s2   <= rw_s1;
         data_s1 <= bus.LCD_DATA;
         data_s2 <= data_s1;
      end
   end

   assign fall_c = e_d & ~e_s2;

   // Strobe decode; a count of 1 means busy expires this cycle, so a strobe is still accepted
   always_comb begin
      addr_nx     = addr;
      id_nx       = id;
      disp_nx     = disp;
      cnt_nx      = (cnt != '0) ? cnt - CNT_W'(1) : '0;
      err_nx      = err;
      wr_nx       = 1'b0;
      store_c     = 1'b0;
      store_idx_c = 5'd0;
      clear_c     = 1'b0;

      if (fall_c && !rw_s2) begin
         if (cnt > CNT_W'(1)) begin
            err_nx = 1'b1;
         end else if (rs_s2) begin
            cnt_nx = CNT_W'(CMD_CYCLES);
            if (addr[6:4] == 3'b000) begin
               store_c     = 1'b1;
               store_idx_c = {1'b0, addr[3:0]};
            end else if (addr[6:4] == 3'b100) begin
               store_c     = 1'b1;
               store_idx_c = {1'b1, addr[3:0]};
            end
            wr_nx   = store_c;
            addr_nx = id ? addr + 7'd1 : addr - 7'd1;
         end else begin
            cnt_nx = CNT_W'(CMD_CYCLES);
            casez (data_s2)
               8'b1???????: addr_nx = data_s2[6:0];
               8'b00001???: disp_nx = data_s2[2];
               8'b000001??: id_nx   = data_s2[1];
               8'b0000001?: addr_nx = 7'd0;
               8'b00000001: begin
                  clear_c = 1'b1;
                  addr_nx = 7'd0;
                  id_nx   = 1'b1;
                  cnt_nx  = CNT_W'(CLR_CYCLES);
               end
               default: ;
            endcase
         end
      end

      busy_nx = (cnt_nx != '0);
   end

   // Architectural state and display buffer
   always_ff @(posedge CLK_1M or negedge RESET) begin
      if (!RESET) begin
         addr <= 7'd0;
         id   <= 1'b1;
         disp <= 1'b0;
         cnt  <= '0;
         busy <= 1'b0;
         wr   <= 1'b0;
         err  <= 1'b0;
         for (int i = 0; i < DEPTH; i++) mem[i] <= 8'h20;
      end else begin
         addr <= addr_nx;
         id   <= id_nx;
         disp <= disp_nx;
         cnt  <= cnt_nx;
         busy <= busy_nx;
         wr   <= wr_nx;
         err  <= err_nx;
         if (clear_c) begin
            for (int i = 0; i < DEPTH; i++) mem[i] <= 8'h20;
         end else if (store_c) begin
            mem[store_idx_c] <= data_s2;
         end
      end
   end

   assign bus.RD_CHAR  = mem[bus.RD_ADDR];
   assign bus.ADDR_CNT = addr;
   assign bus.DISP_ON  = disp;
   assign bus.BUSY     = busy;
   assign bus.WR_PULSE = wr;
   assign bus.BUSY_ERR = err;

endmodule

// File: tb/tb_lcd_bus_receiver.sv
// Directed bench for lcd_bus_receiver: host-side strobes with hand-computed
// buffer, address, busy-length and error expectations.
module tb_lcd_bus_receiver;

   logic clk;
   logic RESET;
   int   n_checks;
   int   n_fail;
   int   busy_cnt;
   int   wr_cnt;
   int   b0;
   int   w0;

   lcd_bus_receiver_if bus ();

   lcd_bus_receiver #(.CLR_CYCLES(1640), .CMD_CYCLES(40)) dut (
      .CLK_1M (clk),
      .RESET  (RESET),
      .bus    (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      busy_cnt = 0;
      wr_cnt   = 0;
   end

   // Running totals of BUSY-high cycles and WR_PULSE cycles, sampled mid-cycle
   always @(negedge clk) begin
      if (bus.BUSY)     busy_cnt <= busy_cnt + 1;
      if (bus.WR_PULSE) wr_cnt   <= wr_cnt + 1;
   end

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic chk_char(input int idx, input logic [7:0] exp);
      bus.RD_ADDR = 5'(idx);
      #1;
      chk($sformatf("char%0d", idx), 32'(bus.RD_CHAR), 32'(exp));
   endtask

   // Called at a negedge; E high 3 cycles, low, then 4+gap cycles of hold. Fall-to-fall = gap+7.
   task automatic strobe(input logic rs, input logic rw, input logic [7:0] d, input int gap);
      bus.LCD_RS   = rs;
      bus.LCD_RW   = rw;
      bus.LCD_DATA = d;
      bus.LCD_E    = 1'b1;
      repeat (3) @(negedge clk);
      bus.LCD_E = 1'b0;
      repeat (4 + gap) @(negedge clk);
   endtask

   initial begin
      n_checks     = 0;
      n_fail       = 0;
      RESET        = 1'b0;
      bus.LCD_E    = 1'b0;
      bus.LCD_RS   = 1'b0;
      bus.LCD_RW   = 1'b0;
      bus.LCD_DATA = 8'h00;
      bus.RD_ADDR  = 5'd0;
      repeat (3) @(negedge clk);

      // Reset state
      #1;
      chk("rst_addr", 32'(bus.ADDR_CNT), 32'h00);
      chk("rst_disp", 32'(bus.DISP_ON), 32'h0);
      chk("rst_busy", 32'(bus.BUSY), 32'h0);
      chk("rst_wr", 32'(bus.WR_PULSE), 32'h0);
      chk("rst_err", 32'(bus.BUSY_ERR), 32'h0);
      chk_char(0, 8'h20);
      chk_char(31, 8'h20);
      @(negedge clk);
      RESET = 1'b1;
      repeat (3) @(negedge clk);

      // Line 1 writes, busy length of one command
      w0 = wr_cnt;
      b0 = busy_cnt;
      strobe(1'b0, 1'b0, 8'h80, 50);
      chk("cmd_busy_len", 32'(busy_cnt - b0), 32'd40);
      strobe(1'b1, 1'b0, 8'h41, 50);
      strobe(1'b1, 1'b0, 8'h42, 50);
      chk_char(0, 8'h41);
      chk_char(1, 8'h42);
      chk("l1_addr", 32'(bus.ADDR_CNT), 32'h02);
      chk("l1_wr", 32'(wr_cnt - w0), 32'd2);

      // Line 2 write, then end-of-line discard at 0x10
      strobe(1'b0, 1'b0, 8'hC0, 50);
      strobe(1'b1, 1'b0, 8'h39, 50);
      chk_char(16, 8'h39);
      w0 = wr_cnt;
      strobe(1'b0, 1'b0, 8'h8F, 50);
      strobe(1'b1, 1'b0, 8'h31, 50);
      strobe(1'b1, 1'b0, 8'h31, 50);
      chk_char(15, 8'h31);
      chk_char(16, 8'h39);
      chk("eol_addr", 32'(bus.ADDR_CNT), 32'h11);
      chk("eol_wr", 32'(wr_cnt - w0), 32'd1);

      // Decrement wrap 0x00 -> 0x7F, then increment wrap 0x7F -> 0x00 with discard
      w0 = wr_cnt;
      strobe(1'b0, 1'b0, 8'h04, 50);
      strobe(1'b0, 1'b0, 8'h80, 50);
      strobe(1'b1, 1'b0, 8'h58, 50);
      chk_char(0, 8'h58);
      chk("dec_wrap", 32'(bus.ADDR_CNT), 32'h7F);
      strobe(1'b0, 1'b0, 8'h06, 50);
      strobe(1'b1, 1'b0, 8'h77, 50);
      chk("inc_wrap", 32'(bus.ADDR_CNT), 32'h00);
      chk("wrap_wr", 32'(wr_cnt - w0), 32'd1);
      chk_char(0, 8'h58);

      // Display control and ignored read strobe
      strobe(1'b0, 1'b0, 8'h0C, 50);
      chk("disp_on", 32'(bus.DISP_ON), 32'h1);
      strobe(1'b0, 1'b0, 8'h08, 50);
      chk("disp_off", 32'(bus.DISP_ON), 32'h0);
      b0 = busy_cnt;
      strobe(1'b0, 1'b1, 8'hFF, 50);
      chk("rw_disp", 32'(bus.DISP_ON), 32'h0);
      chk("rw_addr", 32'(bus.ADDR_CNT), 32'h00);
      chk("rw_busy", 32'(busy_cnt - b0), 32'd0);
      chk("rw_err", 32'(bus.BUSY_ERR), 32'h0);

      // Strobe landing exactly in the expiring cycle is accepted back-to-back
      b0 = busy_cnt;
      strobe(1'b0, 1'b0, 8'h02, 33);
      strobe(1'b0, 1'b0, 8'h02, 60);
      chk("edge_err", 32'(bus.BUSY_ERR), 32'h0);
      chk("edge_busy", 32'(busy_cnt - b0), 32'd80);

      // Clear: long busy, a strobe ~1000 cycles in is flagged and dropped
      strobe(1'b0, 1'b0, 8'h80, 50);
      strobe(1'b1, 1'b0, 8'h4B, 50);
      strobe(1'b0, 1'b0, 8'h04, 50);
      b0 = busy_cnt;
      w0 = wr_cnt;
      strobe(1'b0, 1'b0, 8'h01, 993);
      chk("clr_busy_mid", 32'(bus.BUSY), 32'h1);
      strobe(1'b1, 1'b0, 8'h55, 700);
      chk("clr_busy_len", 32'(busy_cnt - b0), 32'd1640);
      chk("clr_err", 32'(bus.BUSY_ERR), 32'h1);
      chk("clr_addr", 32'(bus.ADDR_CNT), 32'h00);
      chk("clr_wr", 32'(wr_cnt - w0), 32'd0);
      for (int i = 0; i < 32; i++) chk_char(i, 8'h20);
      strobe(1'b1, 1'b0, 8'h61, 50);
      chk_char(0, 8'h61);
      chk("post_clr_addr", 32'(bus.ADDR_CNT), 32'h01);
      chk("err_sticky", 32'(bus.BUSY_ERR), 32'h1);

      // Reset during command busy
      strobe(1'b0, 1'b0, 8'h0C, 50);
      strobe(1'b0, 1'b0, 8'h85, 5);
      chk("pre_rst_busy", 32'(bus.BUSY), 32'h1);
      chk("pre_rst_addr", 32'(bus.ADDR_CNT), 32'h05);
      RESET = 1'b0;
      #1;
      chk("mid_rst_busy", 32'(bus.BUSY), 32'h0);
      chk("mid_rst_addr", 32'(bus.ADDR_CNT), 32'h00);
      chk("mid_rst_disp", 32'(bus.DISP_ON), 32'h0);
      chk("mid_rst_err", 32'(bus.BUSY_ERR), 32'h0);
      chk_char(0, 8'h20);
      @(negedge clk);
      RESET = 1'b1;
      b0 = busy_cnt;
      repeat (50) @(negedge clk);
      chk("post_rst_busy", 32'(busy_cnt - b0), 32'd0);
      chk("post_rst_addr", 32'(bus.ADDR_CNT), 32'h00);

      // Reset during a strobe: E falls while in reset, nothing is decoded afterwards
      bus.LCD_RS   = 1'b0;
      bus.LCD_RW   = 1'b0;
      bus.LCD_DATA = 8'h8A;
      bus.LCD_E    = 1'b1;
      repeat (3) @(negedge clk);
      RESET = 1'b0;
      @(negedge clk);
      bus.LCD_E = 1'b0;
      repeat (2) @(negedge clk);
      RESET = 1'b1;
      b0 = busy_cnt;
      repeat (50) @(negedge clk);
      chk("mid_strobe_addr", 32'(bus.ADDR_CNT), 32'h00);
      chk("mid_strobe_busy", 32'(busy_cnt - b0), 32'd0);

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
